// File: rtl/sdsu_bus_pkg.sv
// Shared constants and types for the SDSU register-bus responder.
// SDSU_SIGNED_MUL_EN selects a two's-complement multiply in the datapath.
package sdsu_bus_pkg;

  localparam int unsigned OP_W_DEFAULT   = 16;

  localparam int unsigned ADDR_CTRL      = 0;
  localparam int unsigned ADDR_OPA       = 1;
  localparam int unsigned ADDR_OPB       = 2;

  localparam int unsigned CTRL_START_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } resp_state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one partial product per clock, OP_W steps.
// With SDSU_SIGNED_MUL_EN the operands are two's complement.
module seq_mul
  import sdsu_bus_pkg::*;
#(
  parameter int unsigned OP_W = OP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              done,
  output logic [2*OP_W-1:0] product
);

  localparam int unsigned PW    = 2 * OP_W;
  localparam int unsigned CNT_W = $clog2(OP_W + 1);

  logic [OP_W-1:0]  mcand_q, mcand_d;
  logic [OP_W-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             run_q, run_d;

  logic [PW-1:0]    pp_c;
  logic [PW-1:0]    step_acc_c;
  logic             last_c;

  // One step of the shift-add; the sign bit's weight is negative in the signed build
  always_comb begin
`ifdef SDSU_SIGNED_MUL_EN
    pp_c = PW'($signed(mcand_q)) << count_q;
`else
    pp_c = PW'(mcand_q) << count_q;
`endif
    step_acc_c = acc_q;
    if (mplier_q[0]) begin
`ifdef SDSU_SIGNED_MUL_EN
      if (count_q == CNT_W'(OP_W - 1)) step_acc_c = acc_q - pp_c;
      else                             step_acc_c = acc_q + pp_c;
`else
      step_acc_c = acc_q + pp_c;
`endif
    end
    last_c = run_q && (count_q == CNT_W'(OP_W - 1));
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    run_d    = run_q;
    if (go) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      count_d  = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = step_acc_c;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CNT_W'(1);
      if (last_c) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      run_q    <= run_d;
    end
  end

  // Final product is presented on the edge that completes the last step
  assign done    = last_c;
  assign product = step_acc_c;

endmodule

// File: rtl/bus_responder.sv
// SDSU register-bus slave: operand/control register decode, multiply handshake FSM.
// SDSU_SIGNED_MUL_EN builds a signed multiply with a sign-extended result.
module bus_responder
  import sdsu_bus_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OP_W   = OP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              exec,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] result_data
);

  resp_state_t       state_q, state_d;
  logic [OP_W-1:0]   opa_q, opa_d;
  logic [OP_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              accept_c;
  logic              wr_ctrl_c;
  logic              start_cmd_c;
  logic              go_c;
  logic              mul_done;
  logic [2*OP_W-1:0] mul_product;
  logic              unused_data_c;

  assign accept_c      = valid && exec && write;
  assign wr_ctrl_c     = accept_c && (address == ADDR_W'(ADDR_CTRL));
  assign start_cmd_c   = wr_ctrl_c && (start || data[CTRL_START_BIT]);
  assign unused_data_c = ^data[DATA_W-1:OP_W];

  // Operand registers accept writes in every state
  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    if (accept_c && (address == ADDR_W'(ADDR_OPA))) opa_d = data[OP_W-1:0];
    if (accept_c && (address == ADDR_W'(ADDR_OPB))) opb_d = data[OP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_cmd_c) state_d = BUSY;
      BUSY:    if (mul_done)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Starts arriving outside IDLE are dropped
  always_comb begin
    go_c     = (state_q == IDLE) && start_cmd_c;
    ready_d  = (state_d == DONE);
    busy_d   = (state_d != IDLE);
    result_d = result_q;
    if ((state_q == BUSY) && mul_done) begin
`ifdef SDSU_SIGNED_MUL_EN
      result_d = DATA_W'($signed(mul_product));
`else
      result_d = DATA_W'(mul_product);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  seq_mul #(
    .OP_W (OP_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go_c),
    .a       (opa_q),
    .b       (opb_q),
    .done    (mul_done),
    .product (mul_product)
  );

  assign ready       = ready_q;
  assign busy        = busy_q;
  assign result_data = result_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder (either SDSU_SIGNED_MUL_EN build).
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, exec, write, start;
  logic [31:0] address, data;
  logic        ready, busy;
  logic [31:0] result_data;

  int total = 0;
  int bad   = 0;
  int first, pulses, busy_after;

  always #5 clk = ~clk;

  bus_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (valid),
    .exec        (exec),
    .write       (write),
    .address     (address),
    .data        (data),
    .start       (start),
    .ready       (ready),
    .busy        (busy),
    .result_data (result_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one transfer from a falling edge; returns at the falling edge after acceptance
  task automatic xfer(input logic v, input logic e, input logic w,
                      input logic [31:0] a, input logic [31:0] d, input logic s);
    valid = v; exec = e; write = w; address = a; data = d; start = s;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; exec = 1'b0; write = 1'b0; address = '0; data = '0; start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic s);
    xfer(1'b1, 1'b1, 1'b1, a, d, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Cycles counted from the accepting edge; bounded by max_cyc
  task automatic wait_ready(input int max_cyc, output int f, output int p, output int ba);
    f = -1; p = 0; ba = -1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (f >= 0 && n == f + 1) ba = int'(busy);
      if (ready === 1'b1) begin
        p++;
        if (f < 0) f = n;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0; exec = 1'b0; write = 1'b0; start = 1'b0;
    address = '0; data = '0;
    idle(2);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", result_data, 32'h0);
    rst_n = 1'b1;
    idle(1);

    // 3 x 5, latency and pulse width
    wr(32'd1, 32'd3, 1'b0);
    wr(32'd2, 32'd5, 1'b0);
    wr(32'd0, 32'd0, 1'b1);
    chk("t1_ready_early", 32'(ready), 32'd0);
    chk("t1_busy_on", 32'(busy), 32'd1);
    wait_ready(40, first, pulses, busy_after);
    chk("t1_latency", 32'(first), 32'd16);
    chk("t1_pulses", 32'(pulses), 32'd1);
    chk("t1_result", result_data, 32'h0000000F);
    chk("t1_busy_fall", 32'(busy_after), 32'd0);

    // 0x7FFF squared
    wr(32'd1, 32'h7FFF, 1'b0);
    wr(32'd2, 32'h7FFF, 1'b0);
    wr(32'd0, 32'd0, 1'b1);
    wait_ready(20, first, pulses, busy_after);
    chk("t2_latency", 32'(first), 32'd16);
    chk("t2_result", result_data, 32'h3FFF0001);

    // 0xFFFE x 3
    wr(32'd1, 32'hFFFE, 1'b0);
    wr(32'd2, 32'd3, 1'b0);
    wr(32'd0, 32'd0, 1'b1);
    wait_ready(20, first, pulses, busy_after);
    chk("t3_pulses", 32'(pulses), 32'd1);
`ifdef SDSU_SIGNED_MUL_EN
    chk("t3_result", result_data, 32'hFFFFFFFA);
`else
    chk("t3_result", result_data, 32'h0002FFFA);
`endif

    // Mid-op operand write and second start are ignored by the running multiply
    wr(32'd1, 32'd3, 1'b0);
    wr(32'd2, 32'd5, 1'b0);
    wr(32'd0, 32'd0, 1'b1);
    idle(4);
    wr(32'd1, 32'd9, 1'b0);
    wr(32'd0, 32'd0, 1'b1);
    wait_ready(40, first, pulses, busy_after);
    chk("t4_latency", 32'(first), 32'd10);
    chk("t4_pulses", 32'(pulses), 32'd1);
    chk("t4_result", result_data, 32'h0000000F);
    wr(32'd0, 32'd0, 1'b1);
    wait_ready(20, first, pulses, busy_after);
    chk("t4_third_latency", 32'(first), 32'd16);
    chk("t4_third_result", result_data, 32'h0000002D);

    // Reset mid-multiply
    wr(32'd1, 32'd7, 1'b0);
    wr(32'd2, 32'd7, 1'b0);
    wr(32'd0, 32'd0, 1'b1);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_result_async", result_data, 32'h0);
    chk("t5_busy_async", 32'(busy), 32'd0);
    chk("t5_ready_async", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(40, first, pulses, busy_after);
    chk("t5_no_pulse", 32'(pulses), 32'd0);

    // Transfers that must not be accepted
    wr(32'd1, 32'd2, 1'b0);
    xfer(1'b1, 1'b0, 1'b1, 32'd0, 32'd1, 1'b1);
    xfer(1'b1, 1'b1, 1'b0, 32'd0, 32'd1, 1'b1);
    xfer(1'b1, 1'b1, 1'b1, 32'd3, 32'd1, 1'b1);
    xfer(1'b0, 1'b1, 1'b1, 32'd0, 32'd1, 1'b1);
    xfer(1'b1, 1'b0, 1'b1, 32'd1, 32'd9, 1'b0);
    xfer(1'b1, 1'b1, 1'b0, 32'd1, 32'd9, 1'b0);
    wr(32'd0, 32'd0, 1'b0);
    chk("t6_busy", 32'(busy), 32'd0);
    wait_ready(40, first, pulses, busy_after);
    chk("t6_no_pulse", 32'(pulses), 32'd0);
    chk("t6_busy_idle", 32'(busy), 32'd0);
    // Start through data bit 0; OPA must still hold 2
    wr(32'd2, 32'd5, 1'b0);
    wr(32'd0, 32'd1, 1'b0);
    wait_ready(20, first, pulses, busy_after);
    chk("t6_data_start_latency", 32'(first), 32'd16);
    chk("t6_result", result_data, 32'h0000000A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
Slave end of the SDSU register bus. It accepts the master's valid/exec write transfers into a small register file: two operands plus a control word. On a start command it runs an iterative shift-add multiply. When the multiply finishes it returns the product on result_data with a one-cycle ready pulse, and the master uses that pulse to restart its transaction sequence.

Parameters:
DATA_W, 32, bus data and result width
ADDR_W, 32, bus address width
OP_W, 16, operand width used from each operand register; multiply takes OP_W cycles

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid  input  1  master transfer valid
exec  input  1  master execute strobe; a transfer is accepted only when valid && exec
write  input  1  1 = write transfer; 0 = transfer ignored (no reads supported)
address  input  ADDR_W  register select: 0 = CTRL, 1 = OPA, 2 = OPB; others are ignored
data  input  DATA_W  write data
start  input  1  master start qualifier, sampled only on CTRL writes
ready  output  1  one-cycle pulse: result valid
busy  output  1  high while a multiply is in progress (BUSY or DONE)
result_data  output  DATA_W  last product, held until the next completion

Behaviour:
- Reset (async, rst_n low): state=IDLE; opa, opb, acc, count = 0; ready=0, busy=0, result_data=0. Reset mid-multiply aborts with no ready pulse.
- Accept condition: rising clk with valid && exec && write.
  - Address 1: opa <= data[OP_W-1:0].
  - Address 2: opb <= data[OP_W-1:0].
  - Address 0: a start command when (start || data[0]).
  - Any other address: no effect.
- OPA/OPB writes are accepted in every state. The working copies are latched at start, so mid-op writes do not disturb the running multiply.
- State IDLE: on a start command, latch mcand=opa and mplier=opb, set acc=0 and count=0, go to BUSY; busy=1 from the next cycle. A CTRL write without a start qualifier is a no-op.
- State BUSY: each edge performs one step:
  - if mplier[0]=1, acc += mcand << count;
  - mplier >>= 1;
  - count += 1.
  - After step OP_W (count reaches OP_W), go to DONE and load result_data with acc, zero-extended to DATA_W.
- State DONE: ready=1 for exactly this one cycle. The next edge goes to IDLE.
- Latency: start accepted at edge E → ready high during the cycle following edge E+OP_W. With OP_W=16, ready is sampled high at edge E+17.
- Start command while BUSY or DONE: ignored. No queueing and no error response.
- Arithmetic: unsigned OP_W×OP_W → 2·OP_W-bit product, with no overflow possible. acc is 2·OP_W bits wide.
- If start and an OPA write occur in the same cycle, impossible on a single-address bus; no special handling is needed.
- ready is registered; result_data changes only on the DONE entry edge.

Optional Feature:
SDSU_SIGNED_MUL_EN
- Defined: operands are treated as two's-complement OP_W-bit values.
  - Partial products are sign-extended.
  - The step for bit OP_W-1 subtracts instead of adds (Baugh-Wooley / Booth radix-2 equivalent).
  - result_data is sign-extended to DATA_W.
- Not defined: unsigned multiply as specified above, with zero extension.
- Latency is identical in both builds.

Decomposition:
- Package sdsu_bus_pkg holds:
  - ADDR_CTRL=0, ADDR_OPA=1, ADDR_OPB=2;
  - CTRL_START_BIT=0;
  - typedef enum resp_state_t {IDLE, BUSY, DONE};
  - the default OP_W.
- Sub-module seq_mul (OP_W parameter; ports clk, rst_n, go, a, b, done, product) holds the shift-add datapath and counter. bus_responder keeps the decode, register file and handshake FSM.

Test Plan:
1. Write OPA=3, OPB=5, then CTRL with start=1 → ready high one cycle exactly 17 edges later; result_data=0x0000000F; busy falls the cycle after.
2. OPA=0x7FFF, OPB=0x7FFF, start → result_data=0x3FFF0001 in both builds.
3. OPA=0xFFFE, OPB=3, start →
   - without SDSU_SIGNED_MUL_EN: result_data=0x0002FFFA;
   - with it: result_data=0xFFFFFFFA (-6).
4. Start, then at edge +5 write OPA=9 and issue a second start → first result is unchanged and ready pulses once only. A third start after ready then uses OPA=9.
5. Start with OPA=7, OPB=7; drop rst_n at edge +8 → ready never pulses; result_data=0, busy=0 immediately (async).
6. Transfers with exec=0, write=0, or address=3 carrying start=1 → no state change; ready stays 0 for 40 cycles.
